alu_issue_stage: RTL and testbench

//   Decode/issue stage that drives the ALU's operand and control inputs. Accepts instruction+PC from

---
 rtl/alu_issue_stage.sv | 181 ++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode/issue stage feeding ALU operands and control through a 2-entry skid buffer
module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_op1,
  output logic [DATA_WIDTH-1:0] out_op2,
  output logic [3:0]            out_ctrl,
  output logic [4:0]            out_rd,
  output logic                  out_we,
  output logic                  out_branch,
  output logic [DATA_WIDTH-1:0] out_target,
  output logic                  out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [3:0]            ctrl;
    logic [4:0]            rd;
    logic                  we;
    logic                  branch;
    logic [DATA_WIDTH-1:0] target;
    logic                  illegal;
  } entry_t;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  logic [DATA_WIDTH-1:0] imm_i;
  logic [DATA_WIDTH-1:0] imm_b;
  logic [DATA_WIDTH-1:0] imm_u;

  entry_t dec;
  logic   legal;
  logic   writes_rd;

  entry_t main_q;
  entry_t skid_q;
  logic   main_valid;
  logic   skid_valid;
  logic   accept;
  logic   retire;

  assign opcode   = in_instr[6:0];
  assign funct3   = in_instr[14:12];
  assign funct7   = in_instr[31:25];
  assign rd_field = in_instr[11:7];
  assign rs1_addr = in_instr[19:15];
  assign rs2_addr = in_instr[24:20];

  assign imm_i = {{(DATA_WIDTH-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_b = {{(DATA_WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};

  always_comb begin
    dec       = '0;
    dec.rd    = rd_field;
    legal     = 1'b1;
    writes_rd = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.op1   = rs1_data;
        dec.op2   = rs2_data;
        dec.ctrl  = {funct7[5], funct3};
        writes_rd = 1'b1;
        legal     = (funct7 == 7'h00) ||
                    ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        dec.op1   = rs1_data;
        dec.op2   = imm_i;
        writes_rd = 1'b1;
        // Only the right shift carries an arithmetic/logical selector in funct7.
        if (funct3 == 3'b101) begin
          dec.ctrl = {funct7[5], funct3};
          legal    = (funct7 == 7'h00) || (funct7 == 7'h20);
        end else begin
          dec.ctrl = {1'b0, funct3};
          legal    = (funct3 != 3'b001) || (funct7 == 7'h00);
        end
      end
      OPC_BRANCH: begin
        dec.op1    = rs1_data;
        dec.op2    = rs2_data;
        dec.ctrl   = {1'b0, funct3};
        dec.branch = 1'b1;
        dec.target = in_pc + imm_b;
        legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LUI: begin
        dec.op2   = imm_u;
        writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op1   = in_pc;
        dec.op2   = imm_u;
        writes_rd = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    dec.we = writes_rd && (rd_field != 5'd0);

    // Illegal encodings still issue with a neutral payload so execute can trap on them.
    if (!legal) begin
      dec.op1     = '0;
      dec.op2     = '0;
      dec.ctrl    = 4'b0000;
      dec.we      = 1'b0;
      dec.branch  = 1'b0;
      dec.target  = '0;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && in_ready;
  assign retire   = main_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!main_valid || retire) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        main_valid <= 1'b1;
        skid_valid <= accept;
        if (accept) begin
          skid_q <= dec;
        end
      end else begin
        main_valid <= accept;
        if (accept) begin
          main_q <= dec;
        end
      end
    end else if (accept) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
    end
  end

  assign out_valid   = main_valid;
  assign out_op1     = main_q.op1;
  assign out_op2     = main_q.op2;
  assign out_ctrl    = main_q.ctrl;
  assign out_rd      = main_q.rd;
  assign out_we      = main_q.we;
  assign out_branch  = main_q.branch;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op1;
  logic [31:0] out_op2;
  logic [3:0]  out_ctrl;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_branch;
  logic [31:0] out_target;
  logic        out_illegal;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
    .out_ctrl(out_ctrl), .out_rd(out_rd), .out_we(out_we), .out_branch(out_branch),
    .out_target(out_target), .out_illegal(out_illegal)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic [31:0] tgt;
    logic        ill;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  int total  = 0;
  int passed = 0;
  logic [107:0] q [$];
  logic [107:0] exp_e [3];

  task automatic chk(input string name, input logic [107:0] act, input logic [107:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [107:0] out_entry();
    return {out_op1, out_op2, out_ctrl, out_rd, out_we, out_branch, out_target, out_illegal};
  endfunction

  // Reference decode straight from the instruction-set rules, using integer arithmetic.
  function automatic logic [107:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                              input logic [31:0] a, input logic [31:0] b);
    int          f3, f7, opc, iv;
    logic [31:0] op1, op2, tgt, off;
    logic [3:0]  ctrl;
    bit          we, br, ok;
    opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    op1 = 0; op2 = 0; tgt = 0; ctrl = 0; we = 0; br = 0; ok = 1;
    if (opc == 'h33) begin
      op1 = a; op2 = b; ctrl = 4'(f3 + ((f7 >= 32) ? 8 : 0)); we = 1;
      ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
    end else if (opc == 'h13) begin
      iv = ins[31:20];
      if (iv >= 2048) iv = iv - 4096;
      op1 = a; op2 = iv; we = 1;
      ctrl = 4'(f3 + ((f3 == 5 && f7 >= 32) ? 8 : 0));
      if (f3 == 1) ok = (f7 == 0);
      else if (f3 == 5) ok = (f7 == 0 || f7 == 32);
    end else if (opc == 'h63) begin
      off = ins[11:8] * 2 + ins[30:25] * 32 + ins[7] * 2048;
      if (ins[31]) off = off - 4096;
      op1 = a; op2 = b; ctrl = 4'(f3); br = 1; tgt = pc + off;
      ok = !(f3 == 2 || f3 == 3);
    end else if (opc == 'h37) begin
      op2 = ins[31:12] * 4096; we = 1;
    end else if (opc == 'h17) begin
      op1 = pc; op2 = ins[31:12] * 4096; we = 1;
    end else begin
      ok = 0;
    end
    if (ins[11:7] == 0) we = 0;
    if (!ok) begin
      op1 = 0; op2 = 0; ctrl = 0; we = 0; br = 0; tgt = 0;
    end
    return {op1, op2, ctrl, ins[11:7], we, br, tgt, !ok};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          sel;
    r   = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: begin r[6:0] = 7'h33; r[31:25] = (r[26:25] == 0) ? 7'h20 : (r[26:25] == 1) ? 7'h01 : 7'h00; end
      3, 4:    begin r[6:0] = 7'h13; if (r[27]) r[31:25] = r[28] ? 7'h20 : 7'h00; end
      5:       r[6:0] = 7'h63;
      6:       r[6:0] = 7'h37;
      7:       r[6:0] = 7'h17;
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    vecs[0]  = '{32'h002081B3, 32'h0,        32'd5,        32'd7,    32'd5,        32'd7,        4'h0, 5'd3,  1'b1, 1'b0, 32'h0,  1'b0};
    vecs[1]  = '{32'h40435293, 32'h0,        32'h80000000, 32'h1234, 32'h80000000, 32'h404,      4'hD, 5'd5,  1'b1, 1'b0, 32'h0,  1'b0};
    vecs[2]  = '{32'hFE209CE3, 32'h100,      32'd9,        32'd9,    32'd9,        32'd9,        4'h1, 5'd25, 1'b0, 1'b1, 32'hF8, 1'b0};
    vecs[3]  = '{32'h1234567F, 32'h40,       32'd1,        32'd2,    32'h0,        32'h0,        4'h0, 5'd12, 1'b0, 1'b0, 32'h0,  1'b1};
    vecs[4]  = '{32'h022081B3, 32'h40,       32'd1,        32'd2,    32'h0,        32'h0,        4'h0, 5'd3,  1'b0, 1'b0, 32'h0,  1'b1};
    vecs[5]  = '{32'h402081B3, 32'h0,        32'd5,        32'd7,    32'd5,        32'd7,        4'h8, 5'd3,  1'b1, 1'b0, 32'h0,  1'b0};
    vecs[6]  = '{32'h00208033, 32'h0,        32'd11,       32'd12,   32'd11,       32'd12,       4'h0, 5'd0,  1'b0, 1'b0, 32'h0,  1'b0};
    vecs[7]  = '{32'hABCDE537, 32'h0,        32'd3,        32'd4,    32'h0,        32'hABCDE000, 4'h0, 5'd10, 1'b1, 1'b0, 32'h0,  1'b0};
    vecs[8]  = '{32'h00001097, 32'h200,      32'd3,        32'd4,    32'h200,      32'h1000,     4'h0, 5'd1,  1'b1, 1'b0, 32'h0,  1'b0};
    vecs[9]  = '{32'hFFF10093, 32'h0,        32'd10,       32'd4,    32'd10,       32'hFFFFFFFF, 4'h0, 5'd1,  1'b1, 1'b0, 32'h0,  1'b0};
    vecs[10] = '{32'h40111093, 32'h0,        32'd10,       32'd4,    32'h0,        32'h0,        4'h0, 5'd1,  1'b0, 1'b0, 32'h0,  1'b1};
    vecs[11] = '{32'h0020A063, 32'h300,      32'd10,       32'd4,    32'h0,        32'h0,        4'h0, 5'd0,  1'b0, 1'b0, 32'h0,  1'b1};
    vecs[12] = '{32'h00208863, 32'hFFFFFFF8, 32'd6,        32'd8,    32'd6,        32'd8,        4'h0, 5'd16, 1'b0, 1'b1, 32'h8,  1'b0};
    vecs[13] = '{32'h00435293, 32'h0,        32'hF0,       32'd0,    32'hF0,       32'd4,        4'h5, 5'd5,  1'b1, 1'b0, 32'h0,  1'b0};
    vecs[14] = '{32'hFFF36293, 32'h0,        32'h55,       32'd0,    32'h55,       32'hFFFFFFFF, 4'h6, 5'd5,  1'b1, 1'b0, 32'h0,  1'b0};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; rs1_data = '0; rs2_data = '0;
    #12;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_data", out_entry(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      in_valid = 1'b1; out_ready = 1'b1;
      in_instr = vecs[i].instr; in_pc = vecs[i].pc;
      rs1_data = vecs[i].rs1;   rs2_data = vecs[i].rs2;
      #1;
      chk("rs1_addr", rs1_addr, in_instr[19:15]);
      chk("rs2_addr", rs2_addr, in_instr[24:20]);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_entry", i), out_entry(),
          {vecs[i].op1, vecs[i].op2, vecs[i].ctrl, vecs[i].rd, vecs[i].we, vecs[i].br, vecs[i].tgt, vecs[i].ill});
    end
    @(negedge clk);
    chk("drain_empty", out_valid, 1'b0);

    // Backpressure: third back-to-back instruction must be refused, first two kept in order.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h00000013 | ((k + 1) << 7) | ((k + 1) << 20);
      in_pc = 32'h1000 + 4 * k;
      rs1_data = $urandom; rs2_data = $urandom;
      exp_e[k] = ref_decode(in_instr, in_pc, rs1_data, rs2_data);
      #1;
      chk($sformatf("bp_in_ready%0d", k), in_ready, k < 2);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_hold_first", out_entry(), exp_e[0]);
    out_ready = 1'b1;
    #1;
    chk("bp_out_valid0", out_valid, 1'b1);
    chk("bp_order0", out_entry(), exp_e[0]);
    @(negedge clk);
    chk("bp_out_valid1", out_valid, 1'b1);
    chk("bp_order1", out_entry(), exp_e[1]);
    @(negedge clk);
    chk("bp_no_dup", out_valid, 1'b0);

    // Flush with a full buffer, then flush with only main occupied and input accepted.
    for (int m = 0; m < 2; m++) begin
      out_ready = 1'b0;
      for (int k = 0; k < 2 - m; k++) begin
        in_valid = 1'b1; in_instr = 32'h002081B3; rs1_data = k; rs2_data = 1;
        @(negedge clk);
      end
      flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093;
      #1;
      chk($sformatf("flush%0d_in_ready_pre", m), in_ready, m == 1);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      chk($sformatf("flush%0d_out_valid", m), out_valid, 1'b0);
      chk($sformatf("flush%0d_in_ready", m), in_ready, 1'b1);
      @(negedge clk);
      chk($sformatf("flush%0d_no_issue", m), out_valid, 1'b0);
    end

    // Asynchronous reset mid-cycle with a full buffer.
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_instr = 32'h00208033 | (32'(k + 4) << 7); rs1_data = 32'hDEAD0000 + k;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_data", out_entry(), '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 800; c++) begin
      logic acc;
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_instr  = rand_instr();
      in_pc     = $urandom;
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      #1;
      chk("rnd_in_ready", in_ready, q.size() < 2);
      chk("rnd_out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) chk("rnd_entry", out_entry(), q[0]);
      if (flush) begin
        q.delete();
      end else begin
        acc = in_valid && (q.size() < 2);
        if (out_ready && q.size() > 0) void'(q.pop_front());
        if (acc) q.push_back(ref_decode(in_instr, in_pc, rs1_data, rs2_data));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
